match_controller: RTL and testbench
===================================

# match_controller

Round sequencer and scoreboard for the two-input comparator datapath. It issues one compare request per round and waits for the comparator's 2-bit verdict. It awards the point to player 1 or player 2, or counts a tie, and ends the match on a target score or a round limit. It sits between the front-panel start/clear controls and the comparator, and drives the score displays and the winner LEDs.

## Interface
- SCORE_W, 4: width of each score counter.
- TARGET, 5: points needed to win outright; must be ≤ 2^SCORE_W−1.
- MAX_ROUNDS, 9: round limit; width of round counter is ceil(log2(MAX_ROUNDS+1)).
- TIMEOUT, 15: cycles to wait for comp_valid before the round is scored as a tie.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; begin a match when sampled high in IDLE or DONE.
- clear  in  1  synchronous abort; return to IDLE, zero all state.
- comp_out  in  2  comparator verdict: 2'b10 = player 1 point, 2'b01 = player 2 point, 2'b00/2'b11 = tie.
- comp_valid  in  1  comp_out is valid this cycle.
- comp_req  out  1  one-cycle pulse requesting a new comparison.
- score1, score2  out  SCORE_W  current scores.
- round  out  ceil(log2(MAX_ROUNDS+1))  completed rounds.
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw; valid when done=1.
- busy  out  1  high in REQ/WAIT/CHECK.
- done  out  1  high in DONE.
- timeout_flag  out  1  sticky: at least one round in this match timed out.

## Operation
- Reset (rst_n low, asynchronous): state=IDLE. All outputs 0.
- clear (synchronous, any state): next state IDLE; scores, round, winner and timeout_flag are cleared. clear has priority over start and comp_valid in the same cycle.
- IDLE: if start=1, zero the scores, round, winner and timeout_flag, then go to REQ.
- REQ: comp_req=1 for exactly this cycle. Load the wait counter with 0. Go to WAIT.
- WAIT: comp_valid is sampled only in this state. comp_valid in REQ/CHECK/IDLE/DONE is ignored.
  - comp_valid=1 with 2'b10: score1 += 1.
  - comp_valid=1 with 2'b01: score2 += 1.
  - comp_valid=1 with a tie code: no score change.
  - In all three cases: round += 1, go to CHECK.
  - No comp_valid and wait counter = TIMEOUT−1: tie; round += 1, timeout_flag=1, go to CHECK.
  - Otherwise: wait counter += 1.
- CHECK: uses the updated registers. Conditions are evaluated in this order:
  - score1 == TARGET: winner=01, go to DONE.
  - score2 == TARGET: winner=10, go to DONE.
  - round == MAX_ROUNDS: winner = 01 if score1>score2, 10 if score2>score1, 11 if equal; go to DONE.
  - Otherwise: go to REQ.
- DONE: hold scores and winner. start=1 begins a new match, exactly as from IDLE.
- start while busy is ignored.
- Arithmetic: only one score changes per round, and CHECK ends the match at TARGET, so scores never exceed TARGET and no wrap logic is needed. The round counter never exceeds MAX_ROUNDS.

## Timing
- All outputs are registered and change on the clk rising edge only, except on asynchronous reset.
- start sampled at edge N: REQ during cycle N+1 (comp_req=1, busy=1). WAIT from cycle N+2.
- comp_valid sampled at edge M in WAIT: score and round visible in cycle M+1 (CHECK). REQ or DONE in cycle M+2.
- Minimum round is 3 cycles (REQ, WAIT, CHECK). Maximum round is TIMEOUT+2 cycles.
- Timeout: with no comp_valid, the TIMEOUT-th WAIT cycle is the last one, and CHECK follows.
- done rises in the cycle after the deciding CHECK. winner is stable from that cycle until the next start, clear or reset.
- Reset asserted mid-round: all outputs drop to 0 immediately. comp_req is never extended or re-emitted after release.

## Test plan
- Reset mid-WAIT with score1=3 -> all outputs 0 at once. After rst_n releases, state stays IDLE until start.
- start, then comp_valid with 2'b10 one cycle after each comp_req for 5 rounds -> score1=5, score2=0, round=5, winner=01, done=1. comp_req seen exactly 5 times, 3 cycles apart.
- 9 rounds alternating 2'b10/2'b01, with ties in rounds 8 and 9 -> round=9, score1=4, score2=3, winner=01. Repeat with equal scores -> winner=11.
- No comp_valid after comp_req -> CHECK after 15 WAIT cycles, round +1, scores unchanged, timeout_flag=1 and held until the next start.
- comp_valid asserted during the REQ and CHECK cycles -> ignored, no score change. start during WAIT -> no effect.
- clear and start in the same cycle while in DONE -> IDLE, all zero, no comp_req. start the next cycle -> new match begins normally.

Source files
------------

// File: rtl/match_controller.sv
// ---------------------------------------------------------------------------
// match_controller
//   Round sequencer and scoreboard for the two-input comparator datapath.
//   Each round issues one compare request, waits for the comparator verdict
//   (or a timeout), and awards a point or counts a tie. The match ends when
//   a player reaches TARGET points or when MAX_ROUNDS rounds are complete.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin a match (honoured in IDLE or DONE only)
//   clear        synchronous abort back to IDLE with all state zeroed
//   comp_out     verdict: 10 = player 1, 01 = player 2, 00/11 = tie
//   comp_valid   comp_out valid this cycle (looked at only while waiting)
//   comp_req     one-cycle compare request pulse
//   score1/2     current scores
//   round        completed rounds
//   winner       00 none, 01 player 1, 10 player 2, 11 draw
//   busy         round in progress (REQ/WAIT/CHECK)
//   done         match finished
//   timeout_flag at least one round of this match timed out
// ---------------------------------------------------------------------------
module match_controller #(
   parameter int SCORE_W    = 4,
   parameter int TARGET     = 5,
   parameter int MAX_ROUNDS = 9,
   parameter int TIMEOUT    = 15,
   localparam int RND_W     = $clog2(MAX_ROUNDS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               clear,
   input  logic [1:0]         comp_out,
   input  logic               comp_valid,
   output logic               comp_req,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [RND_W-1:0]   round,
   output logic [1:0]         winner,
   output logic               busy,
   output logic               done,
   output logic               timeout_flag
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   localparam logic [SCORE_W-1:0] TARGET_V  = SCORE_W'(TARGET);
   localparam logic [RND_W-1:0]   ROUNDS_V  = RND_W'(MAX_ROUNDS);
   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
   logic [SCORE_W-1:0]  score1_d, score2_d;
   logic [RND_W-1:0]    round_d;
   logic [1:0]          winner_d;
   logic                tflag_d;
   logic                comp_req_d, busy_d, done_d;

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      score1_d = score1;
      score2_d = score2;
      round_d  = round;
      winner_d = winner;
      tflag_d  = timeout_flag;

      if (clear) begin
         state_d  = S_IDLE;
         wcnt_d   = '0;
         score1_d = '0;
         score2_d = '0;
         round_d  = '0;
         winner_d = 2'b00;
         tflag_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  score1_d = '0;
                  score2_d = '0;
                  round_d  = '0;
                  winner_d = 2'b00;
                  tflag_d  = 1'b0;
                  state_d  = S_REQ;
               end
            end
            S_REQ: begin
               wcnt_d  = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (comp_valid) begin
                  // Tie codes (00/11) fall through with no score change.
                  if (comp_out == 2'b10)
                     score1_d = score1 + 1'b1;
                  else if (comp_out == 2'b01)
                     score2_d = score2 + 1'b1;
                  round_d = round + 1'b1;
                  state_d = S_CHECK;
               end else if (wcnt_q == WAIT_LAST) begin
                  round_d = round + 1'b1;
                  tflag_d = 1'b1;
                  state_d = S_CHECK;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
            S_CHECK: begin
               // Outright win is tested before the round limit so a TARGET
               // reached on the last round still counts as a clean win.
               if (score1 == TARGET_V) begin
                  winner_d = 2'b01;
                  state_d  = S_DONE;
               end else if (score2 == TARGET_V) begin
                  winner_d = 2'b10;
                  state_d  = S_DONE;
               end else if (round == ROUNDS_V) begin
                  if (score1 > score2)
                     winner_d = 2'b01;
                  else if (score2 > score1)
                     winner_d = 2'b10;
                  else
                     winner_d = 2'b11;
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Status outputs are registered copies of the next-state decode so
      // they line up with the state they describe.
      comp_req_d = (state_d == S_REQ);
      busy_d     = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_CHECK);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wcnt_q       <= '0;
         score1       <= '0;
         score2       <= '0;
         round        <= '0;
         winner       <= 2'b00;
         timeout_flag <= 1'b0;
         comp_req     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         score1       <= score1_d;
         score2       <= score2_d;
         round        <= round_d;
         winner       <= winner_d;
         timeout_flag <= tflag_d;
         comp_req     <= comp_req_d;
         busy         <= busy_d;
         done         <= done_d;
      end
   end

endmodule

// File: tb/tb_match_controller.sv
// ---------------------------------------------------------------------------
// tb_match_controller
//   Self-checking bench for match_controller: hand-written sequences for
//   reset, timeout timing, ignored inputs and clear, plus a table of whole
//   matches whose final results go through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_match_controller;

   localparam int SCORE_W = 4;
   localparam int RND_W   = $clog2(9 + 1);

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               clear = 1'b0;
   logic [1:0]         comp_out = 2'b00;
   logic               comp_valid = 1'b0;
   logic               comp_req;
   logic [SCORE_W-1:0] score1, score2;
   logic [RND_W-1:0]   round;
   logic [1:0]         winner;
   logic               busy, done, timeout_flag;

   match_controller #(
      .SCORE_W(4), .TARGET(5), .MAX_ROUNDS(9), .TIMEOUT(15)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .comp_out(comp_out), .comp_valid(comp_valid), .comp_req(comp_req),
      .score1(score1), .score2(score2), .round(round), .winner(winner),
      .busy(busy), .done(done), .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   // comp_req pulse monitor: total pulses, pulses exactly 3 cycles after the
   // previous one, and back-to-back (stretched) pulses.
   int   cyc = 0;
   int   req_total = 0;
   int   gap3 = 0;
   int   dbl = 0;
   int   last_req = -100;
   logic prev_req = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (comp_req === 1'b1) begin
         req_total <= req_total + 1;
         if (cyc - last_req == 3) gap3 <= gap3 + 1;
         if (prev_req) dbl <= dbl + 1;
         last_req <= cyc;
      end
      prev_req <= comp_req;
   end

   // Match table: one char per round. '1' = player 1 (10), '2' = player 2
   // (01), '0' = tie 00, '3' = tie 11, 't' = no comp_valid (timeout).
   typedef struct {
      string codes;
      int    s1, s2, rnd, win, tf;
   } rec_t;

   typedef struct {
      int s1, s2, rnd, win, tf;
   } exp_t;

   rec_t tbl[6];
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic set_rec(input int i, input string c, input int a, input int b,
                          input int r, input int w, input int t);
      tbl[i].codes = c;
      tbl[i].s1 = a;
      tbl[i].s2 = b;
      tbl[i].rnd = r;
      tbl[i].win = w;
      tbl[i].tf = t;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string name);
      check(name, 32'({comp_req, score1, score2, round, winner, busy, done, timeout_flag}), 0);
   endtask

   task automatic wait_req();
      for (int i = 0; i < 40; i++) begin
         step();
         if (comp_req === 1'b1) break;
      end
      check("wait_req", 32'(comp_req), 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) break;
         step();
      end
      check("wait_done", 32'(done), 1);
   endtask

   // Called while sampling the REQ cycle; answers in the first WAIT cycle.
   task automatic run_round(input byte c);
      if (c != "t") begin
         step();
         comp_valid = 1'b1;
         comp_out = (c == "1") ? 2'b10 : (c == "2") ? 2'b01 : (c == "3") ? 2'b11 : 2'b00;
         step();
         comp_valid = 1'b0;
      end
   endtask

   task automatic run_match(input int i);
      exp_t e;
      int   req0, g0, exp_gap, n;
      n = tbl[i].codes.len();
      req0 = req_total;
      g0 = gap3;
      exp_gap = 0;
      for (int r = 1; r < n; r++)
         if (tbl[i].codes[r-1] != "t") exp_gap++;
      e.s1 = tbl[i].s1;
      e.s2 = tbl[i].s2;
      e.rnd = tbl[i].rnd;
      e.win = tbl[i].win;
      e.tf = tbl[i].tf;
      sb.push_back(e);

      start = 1'b1;
      step();
      start = 1'b0;
      check("start_req", 32'(comp_req), 1);
      check("start_zero", 32'({round, score1, score2, winner, timeout_flag, done}), 0);

      for (int r = 0; r < n; r++) begin
         if (r > 0) wait_req();
         run_round(tbl[i].codes[r]);
      end
      wait_done();

      if (sb.size() == 0) begin
         check("sb_empty", 32'(sb.size()), 1);
      end else begin
         e = sb.pop_front();
         check("score1", 32'(score1), e.s1);
         check("score2", 32'(score2), e.s2);
         check("round", 32'(round), e.rnd);
         check("winner", 32'(winner), e.win);
         check("tflag", 32'(timeout_flag), e.tf);
         check("busy_done", 32'(busy), 0);
         check("req_count", req_total - req0, n);
         check("req_gap3", gap3 - g0, exp_gap);
      end
   endtask

   initial begin
      set_rec(0, "11111",     5, 0, 5, 1, 0);
      set_rec(1, "121212103", 4, 3, 9, 1, 0);
      set_rec(2, "121212003", 3, 3, 9, 3, 0);
      set_rec(3, "220222",    0, 5, 6, 2, 0);
      set_rec(4, "t11111",    5, 0, 6, 1, 1);
      set_rec(5, "212320000", 1, 3, 9, 2, 0);

      // Reset state, then idle until start.
      #1;
      check_all_zero("reset_zero");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      check("idle_after_reset", 32'({comp_req, busy, done}), 0);
      check("no_req_after_reset", req_total, 0);

      // Timeout: 15 WAIT cycles, then CHECK with round+1 and sticky flag.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (15) step();
      check("to_last_wait_round", 32'(round), 0);
      check("to_last_wait_flag", 32'({busy, timeout_flag}), 32'b10);
      step();
      check("to_check_round", 32'(round), 1);
      check("to_check_flag", 32'(timeout_flag), 1);
      check("to_scores", 32'({score1, score2}), 0);
      step();
      check("to_next_req", 32'({comp_req, timeout_flag}), 32'b11);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_all_zero("clear_mid_round");

      // comp_valid in REQ and CHECK ignored; start during WAIT ignored.
      start = 1'b1;
      step();
      start = 1'b0;
      comp_valid = 1'b1;
      comp_out = 2'b10;
      step();
      comp_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      check("ign_wait", 32'({busy, comp_req, score1}), 32'b10_0000);
      comp_valid = 1'b1;
      comp_out = 2'b01;
      step();
      check("ign_check_scores", 32'({score1, score2, round}), 32'h011);
      comp_valid = 1'b1;
      comp_out = 2'b10;
      step();
      comp_valid = 1'b0;
      check("ign_next_req", 32'({comp_req, score1, score2}), 32'h101);
      clear = 1'b1;
      step();
      clear = 1'b0;

      // Full matches through the scoreboard.
      for (int i = 0; i < 6; i++) run_match(i);

      // clear + start together in DONE: clear wins, then a clean restart.
      clear = 1'b1;
      start = 1'b1;
      step();
      clear = 1'b0;
      start = 1'b0;
      check_all_zero("clear_start_done");
      run_match(0);

      // Asynchronous reset in the middle of WAIT with score1 = 3.
      start = 1'b1;
      step();
      start = 1'b0;
      run_round("1");
      wait_req();
      run_round("1");
      wait_req();
      run_round("1");
      wait_req();
      step();
      check("pre_reset_score", 32'({busy, score1}), 32'h13);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int r0;
         r0 = req_total;
         repeat (4) step();
         check("post_reset_idle", 32'({comp_req, busy, done}), 0);
         check("post_reset_no_req", req_total - r0, 0);
      end
      check("req_never_stretched", dbl, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
